// File: rtl/decoder_5_32.sv
// Registered binary-to-one-hot decoder with valid/index sideband and optional active-low output.
// Optional macro DECODER_HOLD_LAST_EN: an invalid input cycle keeps out/out_idx instead of clearing them.
module decoder_5_32 #(
  parameter int IN_W       = 5,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W     = 2 ** IN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [IN_W-1:0]   in,
  input  logic              in_valid,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  output logic [IN_W-1:0]   out_idx
);

  // Idle pattern: no line selected, which is all ones when the bus is active-low.
  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] decoded;

  always_comb begin
    onehot  = OUT_W'(1) << in;
    decoded = ACTIVE_LOW ? ~onehot : onehot;
  end

  // Reset beats enable; a stall freezes every register including out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= INACTIVE;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else if (en) begin
      if (in_valid) begin
        out       <= decoded;
        out_valid <= 1'b1;
        out_idx   <= in;
      end else begin
        out_valid <= 1'b0;
`ifdef DECODER_HOLD_LAST_EN
        out       <= out;
        out_idx   <= out_idx;
`else
        out       <= INACTIVE;
        out_idx   <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_decoder_5_32.sv
// Table-driven bench for decoder_5_32; drives an active-high and an active-low instance in parallel.
// Expected values for invalid-input cycles follow DECODER_HOLD_LAST_EN when it is defined.
module tb_decoder_5_32;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [4:0]  in;
    logic [31:0] exp_out;
    logic        exp_valid;
    logic [4:0]  exp_idx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, en, in_valid;
  logic [4:0]  in;
  logic [31:0] out, out_al;
  logic        out_valid, out_valid_al;
  logic [4:0]  out_idx, out_idx_al;

  int compared = 0;
  int mismatched = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  decoder_5_32 #(.IN_W(5), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .in_valid(in_valid),
    .out(out), .out_valid(out_valid), .out_idx(out_idx)
  );

  decoder_5_32 #(.IN_W(5), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .en(en), .in(in), .in_valid(in_valid),
    .out(out_al), .out_valid(out_valid_al), .out_idx(out_idx_al)
  );

  function automatic vec_t mk(string name, logic r, logic e, logic v, logic [4:0] i,
                              logic [31:0] eo, logic ev, logic [4:0] ei);
    vec_t t;
    t.name = name; t.rst = r; t.en = e; t.in_valid = v; t.in = i;
    t.exp_out = eo; t.exp_valid = ev; t.exp_idx = ei;
    return t;
  endfunction

  task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drive inputs mid-cycle, then let one rising edge register them.
  task automatic applyStimulus(input vec_t t);
    rst = t.rst; en = t.en; in_valid = t.in_valid; in = t.in;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t t);
    cmp({t.name, ".out"},          out,                  t.exp_out);
    cmp({t.name, ".out_valid"},    32'(out_valid),       32'(t.exp_valid));
    cmp({t.name, ".out_idx"},      32'(out_idx),         32'(t.exp_idx));
    cmp({t.name, ".al_out"},       out_al,               ~t.exp_out);
    cmp({t.name, ".al_out_valid"}, 32'(out_valid_al),    32'(t.exp_valid));
    cmp({t.name, ".al_out_idx"},   32'(out_idx_al),      32'(t.exp_idx));
    if (t.exp_valid) cmp({t.name, ".popcount"}, 32'($countones(out)), 32'd1);
  endtask

  initial begin
    logic [31:0] inv_out;
    logic [4:0]  inv_idx;
`ifdef DECODER_HOLD_LAST_EN
    inv_out = 32'h0000_0200; inv_idx = 5'd9;
`else
    inv_out = 32'h0000_0000; inv_idx = 5'd0;
`endif

    vecs.push_back(mk("reset0",     1, 1, 1, 5'd7,  32'h0000_0000, 0, 5'd0));
    vecs.push_back(mk("reset1",     1, 1, 1, 5'd7,  32'h0000_0000, 0, 5'd0));
    vecs.push_back(mk("post_reset", 0, 1, 0, 5'd7,  32'h0000_0000, 0, 5'd0));
    vecs.push_back(mk("in0",        0, 1, 1, 5'd0,  32'h0000_0001, 1, 5'd0));
    vecs.push_back(mk("in16",       0, 1, 1, 5'd16, 32'h0001_0000, 1, 5'd16));
    vecs.push_back(mk("in31",       0, 1, 1, 5'd31, 32'h8000_0000, 1, 5'd31));
    for (int i = 0; i < 32; i++)
      vecs.push_back(mk($sformatf("sweep%0d", i), 0, 1, 1, 5'(i), 32'd1 << i, 1, 5'(i)));
    vecs.push_back(mk("stall_pre",  0, 1, 1, 5'd3,  32'h0000_0008, 1, 5'd3));
    vecs.push_back(mk("stall0",     0, 0, 1, 5'd20, 32'h0000_0008, 1, 5'd3));
    vecs.push_back(mk("stall1",     0, 0, 1, 5'd20, 32'h0000_0008, 1, 5'd3));
    vecs.push_back(mk("stall2",     0, 0, 1, 5'd20, 32'h0000_0008, 1, 5'd3));
    vecs.push_back(mk("stall_end",  0, 1, 1, 5'd20, 32'h0010_0000, 1, 5'd20));
    vecs.push_back(mk("inv_pre",    0, 1, 1, 5'd9,  32'h0000_0200, 1, 5'd9));
    vecs.push_back(mk("invalid",    0, 1, 0, 5'd14, inv_out,       0, inv_idx));
    vecs.push_back(mk("inv_stall",  0, 0, 1, 5'd2,  inv_out,       0, inv_idx));
    vecs.push_back(mk("mid1",       0, 1, 1, 5'd1,  32'h0000_0002, 1, 5'd1));
    vecs.push_back(mk("mid_rst",    1, 1, 1, 5'd2,  32'h0000_0000, 0, 5'd0));
    vecs.push_back(mk("mid3",       0, 1, 1, 5'd3,  32'h0000_0008, 1, 5'd3));
    vecs.push_back(mk("prio_pre",   0, 1, 1, 5'd5,  32'h0000_0020, 1, 5'd5));
    vecs.push_back(mk("rst_over_en",1, 0, 1, 5'd6,  32'h0000_0000, 0, 5'd0));

    $display("[TB] start, %0d vectors", vecs.size());
    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      checkOutput(vecs[k]);
    end

    // Hand sequence: after reset under stall, the outputs keep reset values
    // until enable returns, then a single valid index decodes one cycle later.
    begin
      vec_t h;
      h = mk("hs_hold0", 0, 0, 1, 5'd12, 32'h0000_0000, 0, 5'd0);
      applyStimulus(h); checkOutput(h);
      h = mk("hs_hold1", 0, 0, 1, 5'd12, 32'h0000_0000, 0, 5'd0);
      applyStimulus(h); checkOutput(h);
      h = mk("hs_go",    0, 1, 1, 5'd12, 32'h0000_1000, 1, 5'd12);
      applyStimulus(h); checkOutput(h);
      h = mk("hs_b2b",   0, 1, 1, 5'd13, 32'h0000_2000, 1, 5'd13);
      applyStimulus(h); checkOutput(h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
